// File: rtl/load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_pkg
// Description : Shared funct3 encodings, FSM state type and legality helper
//               for the load unit.
// Revision    : 1.0 - initial release
// ============================================================================
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } load_state_t;

    // True for the five funct3 encodings that name a real load
    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_unit_if
// Description : Data-memory read port (request/grant/response) used by the
//               load unit. master = load unit, slave = memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_unit_if
    import load_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational lane select and sign/zero extension of a
//               little-endian memory word into a 32-bit load result.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import load_pkg::*;
(
    input  wire logic [2:0]  funct3,
    input  wire logic [1:0]  offset,
    input  wire logic [31:0] word,
    output logic      [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane, then extend according to the load type
    always_comb begin
        w_byte = word[7:0];
        w_half = offset[1] ? word[31:16] : word[15:0];
        result = '0;
        case (offset)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        case (funct3)
            F3_LB:   result = {{24{w_byte[7]}}, w_byte};
            F3_LH:   result = {{16{w_half[15]}}, w_half};
            F3_LW:   result = word;
            F3_LBU:  result = {24'd0, w_byte};
            F3_LHU:  result = {16'd0, w_half};
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_unit
// Description : Accepts a decoded load, issues one word read to data memory
//               and returns the aligned, extended writeback value. Stalls
//               execute through in_ready while an access is outstanding.
//               Optional macro LOAD_MISALIGN_TRAP_EN: misaligned halfword /
//               word loads skip memory and complete with out_err.
// Revision    : 1.0 - initial release
// ============================================================================
module load_unit
    import load_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    output logic                   in_ready,
    input  wire logic [3:0]        ld_op,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [4:0]        rd,
    load_unit_if.master            mem,
    output logic                   out_valid,
    output logic [4:0]             out_rd,
    output logic [31:0]            out_data,
    output logic                   out_err
);

    load_state_t       r_state;
    load_state_t       w_next;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [4:0]        r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_err;
    logic              w_accept;
    logic              w_reject;
    logic              w_misalign;
    logic [31:0]       w_ext;

    assign w_accept = (r_state == S_IDLE) && in_valid && ld_op[0];

`ifdef LOAD_MISALIGN_TRAP_EN
    assign w_misalign = (((ld_op[3:1] == F3_LH) || (ld_op[3:1] == F3_LHU)) && addr[0]) ||
                        ((ld_op[3:1] == F3_LW) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Rejected loads never touch memory and complete straight from IDLE
    assign w_reject = !f3_legal(ld_op[3:1]) || w_misalign;

    load_extract u_extract (
        .funct3 (r_f3),
        .offset (r_off),
        .word   (mem.mem_rdata),
        .result (w_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; grant/response only count in REQ/WAIT
    always_comb begin
        w_next         = r_state;
        in_ready       = 1'b0;
        mem.mem_req    = 1'b0;
        out_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_reject ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                mem.mem_req = 1'b1;
                if (mem.mem_gnt) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Capture the load on accept and the extracted result on response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f3   <= '0;
            r_off  <= '0;
            r_rd   <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_f3   <= ld_op[3:1];
                r_off  <= addr[1:0];
                r_rd   <= rd;
                r_addr <= {addr[ADDR_W-1:2], 2'b00};
                r_data <= '0;
                r_err  <= w_reject;
            end
            if ((r_state == S_WAIT) && mem.mem_rvalid) begin
                r_data <= w_ext;
            end
        end
    end

    assign mem.mem_addr = r_addr;
    assign out_rd       = r_rd;
    assign out_data     = r_data;
    assign out_err      = r_err;

endmodule
`default_nettype wire

// File: doc/load_unit.md
# load_unit

Memory read-side counterpart of the store path: accepts a decoded load from execute, issues one word read to data memory over a request/grant/response handshake, then aligns and sign/zero-extends the returned word into a 32-bit writeback value. Sits between execute and writeback, beside the store-type decode. It stalls the pipeline via `in_ready` while a read is outstanding.

## Interface
- `ADDR_W`, 32, byte-address width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  load presented by execute
- `in_ready`  out  1  unit can accept; high only in IDLE
- `ld_op`  in  4  bit0 = load enable; bits[3:1] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- `addr`  in  ADDR_W  byte address
- `rd`  in  5  destination register tag
- `mem_req`  out  1  read request; held until granted
- `mem_addr`  out  ADDR_W  word address (`addr` with bits[1:0] = 0)
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read word, little-endian
- `out_valid`  out  1  one-cycle pulse, result valid
- `out_rd`  out  5  tag of completed load
- `out_data`  out  32  extended result
- `out_err`  out  1  illegal funct3 or misaligned access (with out_valid)

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: accept when `in_valid && ld_op[0]`; latch funct3, `addr[1:0]`, `rd`, `mem_addr`. `in_valid` with `ld_op[0]=0` is ignored.
- Illegal funct3 (011, 110, 111): no memory access; go to DONE with `out_err=1`, `out_data=0`.
- Legal op: go to REQ. REQ: `mem_req=1`; go to WAIT on `mem_gnt`.
- WAIT: on `mem_rvalid`, register the extracted result and go to DONE.
- DONE: `out_valid=1` for exactly one cycle, then return to IDLE.
- Extraction: byte lane = `addr[1:0]`; half lane = `addr[1]`. LB/LH sign-extend bit 7/15. LBU/LHU zero-extend. LW passes the word through.
- `mem_gnt`/`mem_rvalid` outside REQ/WAIT are ignored. `mem_rvalid` in the same cycle as `mem_gnt` is not accepted; the response is expected from the next cycle on.
- Reset values: state IDLE, `in_ready=1`, `mem_req=0`, `mem_addr=0`, `out_valid=0`, `out_rd=0`, `out_data=0`, `out_err=0`.
- Reset mid-operation: abandon the access and drop `mem_req` the next cycle. A late `mem_rvalid` after reset is ignored.

## Timing
- Accept at cycle 0.
- `mem_req` is high from cycle 1. With `mem_gnt` in cycle 1 and `mem_rvalid` in cycle 2, `out_valid` is high in cycle 3. Minimum latency is 3 cycles.
- Each stall cycle on `mem_gnt` or `mem_rvalid` adds one cycle.
- `mem_addr` is stable for the whole time `mem_req` is high.
- `in_ready` is low from cycle 1 through the DONE cycle. A new load is accepted at the earliest in the cycle after DONE.
- Illegal funct3: `out_valid` in cycle 1.

## Configuration
- `LOAD_MISALIGN_TRAP_EN` defined:
  - LH/LHU with `addr[0]=1`, or LW with `addr[1:0]!=0`, skips the memory access.
  - It goes directly to DONE with `out_err=1` and `out_data=0`.
- Not defined:
  - Misalignment is not checked. The low address bits are used only for lane selection.
  - LW always reads the aligned word; half lane = `addr[1]`.

## Structure
- Shared package `load_pkg`:
  - funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`)
  - FSM state enum
- Sub-module `load_extract`: purely combinational (funct3, offset[1:0], word) -> 32-bit result. It is instantiated once, in front of the result register.

## Test plan
- LB, `addr=0x1003`, `mem_rdata=0x80FF_1234`, grant and response immediate -> `mem_addr=0x1000`, `out_data=0xFFFF_FF80`, `out_valid` in cycle 3.
- LHU, `addr=0x2002`, `rdata=0xBEEF_0000`, `mem_gnt` delayed 2 cycles -> `mem_req` held with stable address; `out_data=0x0000_BEEF` in cycle 5.
- LW with `ld_op=4'b0101`, `rd=7`, `rdata=0xDEAD_BEEF` -> `out_rd=7`, `out_data=0xDEAD_BEEF`, `out_err=0`; `in_ready` low cycles 1–3.
- Illegal funct3 011 -> no `mem_req`; `out_valid` and `out_err` in cycle 1.
- LH at `addr=0x3001`:
  - With `LOAD_MISALIGN_TRAP_EN`: `out_err=1`, no `mem_req`.
  - Without it: read issued; `out_data` = sign-extended `rdata[15:0]`.
- `rst` asserted in WAIT, then `mem_rvalid` pulses -> `mem_req=0`, no `out_valid`, `in_ready=1` after reset.
